// File: rtl/c2_pkg.sv
// Shared types and defaults for the command & control arbiter.
package c2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ECHO,
    ST_ECHO_WAIT,
    ST_BUSY,
    ST_NAK,
    ST_NAK_WAIT,
    ST_CLEANUP,
    ST_RECOVERY
  } c2_state_e;

  localparam logic [1:0] STATUS_OK      = 2'd0;
  localparam logic [1:0] STATUS_BAD_CMD = 2'd1;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd2;

  // Entry 2i = client i mode 0, entry 2i+1 = client i mode 1.
  localparam logic [3:0][7:0] C2_DEFAULT_CMD_TABLE = {8'hCE, 8'hDE, 8'h1D, 8'h1C};
  localparam logic [7:0]      C2_DEFAULT_NAK_BYTE  = 8'hEE;

  // Width of a client index; never zero so a single-client build still has a port.
  function automatic int c2_client_w(input int num_clients);
    return (num_clients > 1) ? $clog2(num_clients) : 1;
  endfunction

endpackage

// File: rtl/c2_cmd_decoder.sv
// Priority match of a received byte against the command table.
// The lowest matching table index wins, so duplicated bytes resolve to the
// earliest entry.
module c2_cmd_decoder
  import c2_pkg::*;
#(
  parameter int unsigned                     NUM_CLIENTS = 2,
  parameter int unsigned                     CLIENT_W    = 1,
  parameter logic [2*NUM_CLIENTS-1:0][7:0]   CMD_TABLE   = C2_DEFAULT_CMD_TABLE
) (
  input  logic [7:0]          rx_byte_i,
  output logic                hit_o,
  output logic [CLIENT_W-1:0] client_o,
  output logic                mode_o
);

  // Scan from the top down so the last assignment is the lowest matching index.
  always_comb begin
    hit_o    = 1'b0;
    client_o = '0;
    mode_o   = 1'b0;
    for (int i = 2*NUM_CLIENTS-1; i >= 0; i--) begin
      if (rx_byte_i == CMD_TABLE[i]) begin
        hit_o    = 1'b1;
        client_o = CLIENT_W'(i / 2);
        mode_o   = 1'(i % 2);
      end
    end
  end

endmodule

// File: rtl/c2_arbiter_mc.sv
// Multi-client command & control arbiter sitting between the UART core and
// the command-driven engines.
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | waiting for a command byte
// ECHO        | one-cycle echo request of the accepted command
// ECHO_WAIT   | waiting for the transmitter to finish the echo
// BUSY        | client granted, its TX stream muxed to the UART
// NAK         | one-cycle NAK request for an unknown command
// NAK_WAIT    | waiting for the transmitter to finish the NAK
// CLEANUP     | soft reset held for RESET_CYCLES
// RECOVERY    | one quiet cycle before accepting new commands
module c2_arbiter_mc
  import c2_pkg::*;
#(
  parameter int unsigned                   NUM_CLIENTS    = 2,
  parameter logic [2*NUM_CLIENTS-1:0][7:0] CMD_TABLE      = C2_DEFAULT_CMD_TABLE,
  parameter bit                            NAK_ENABLE     = 1'b1,
  parameter logic [7:0]                    NAK_BYTE       = C2_DEFAULT_NAK_BYTE,
  parameter int unsigned                   TIMEOUT_CYCLES = 0,
  parameter int unsigned                   RESET_CYCLES   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [7:0]                 uart_rx_data_i,
  input  logic                       uart_rx_ready_i,
  output logic [7:0]                 uart_tx_data_o,
  output logic                       uart_tx_start_o,
  input  logic                       uart_tx_done_i,
  output logic                       soft_reset_o,
  output logic [NUM_CLIENTS-1:0]     grant_o,
  output logic                       mode_o,
  input  logic [NUM_CLIENTS-1:0]     client_done_i,
  input  logic [8*NUM_CLIENTS-1:0]   client_tx_data_i,
  input  logic [NUM_CLIENTS-1:0]     client_tx_start_i,
  output logic [1:0]                 status_o,
  output logic                       busy_o
);

  localparam int CW = c2_client_w(NUM_CLIENTS);

  c2_state_e            state_q;
  logic [CW-1:0]        client_q;
  logic                 mode_q;
  logic [1:0]           status_q;
  logic [NUM_CLIENTS-1:0] grant_q;
  logic                 soft_reset_q;
  logic                 tx_start_q;
  logic [7:0]           tx_data_q;
  logic [31:0]          cnt_q;

  logic                 dec_hit;
  logic [CW-1:0]        dec_client;
  logic                 dec_mode;
  logic [NUM_CLIENTS-1:0] client_onehot;
  logic                 timeout_hit;

  c2_cmd_decoder #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .CLIENT_W    (CW),
    .CMD_TABLE   (CMD_TABLE)
  ) u_dec (
    .rx_byte_i (uart_rx_data_i),
    .hit_o     (dec_hit),
    .client_o  (dec_client),
    .mode_o    (dec_mode)
  );

  // One-hot form of the latched client, loaded into the grant on BUSY entry.
  always_comb begin
    client_onehot           = '0;
    client_onehot[client_q] = 1'b1;
  end

  // The watchdog counter equals the number of BUSY cycles already spent.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Session sequencer with registered grant, mode, status and soft reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      client_q     <= '0;
      mode_q       <= 1'b0;
      status_q     <= STATUS_OK;
      grant_q      <= '0;
      soft_reset_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (uart_rx_ready_i) begin
            if (dec_hit) begin
              client_q   <= dec_client;
              mode_q     <= dec_mode;
              tx_start_q <= 1'b1;
              tx_data_q  <= uart_rx_data_i;
              state_q    <= ST_ECHO;
            end else begin
              status_q <= STATUS_BAD_CMD;
              if (NAK_ENABLE) begin
                tx_start_q <= 1'b1;
                tx_data_q  <= NAK_BYTE;
                state_q    <= ST_NAK;
              end
            end
          end
        end
        ST_ECHO, ST_ECHO_WAIT: begin
          tx_start_q <= 1'b0;
          tx_data_q  <= 8'h00;
          if (uart_tx_done_i) begin
            grant_q <= client_onehot;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end else begin
            state_q <= ST_ECHO_WAIT;
          end
        end
        ST_BUSY: begin
          if (client_done_i[client_q] || timeout_hit) begin
            // A done in the same cycle as the timeout still counts as success.
            status_q     <= client_done_i[client_q] ? STATUS_OK : STATUS_TIMEOUT;
            grant_q      <= '0;
            soft_reset_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= ST_CLEANUP;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_NAK: begin
          tx_start_q <= 1'b0;
          tx_data_q  <= 8'h00;
          state_q    <= ST_NAK_WAIT;
        end
        ST_NAK_WAIT: begin
          if (uart_tx_done_i) state_q <= ST_IDLE;
        end
        ST_CLEANUP: begin
          if (cnt_q == 32'(RESET_CYCLES - 1)) begin
            soft_reset_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= ST_RECOVERY;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_RECOVERY: begin
          mode_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // During BUSY the granted client drives the transmitter; everyone else is masked.
  always_comb begin
    uart_tx_start_o = tx_start_q;
    uart_tx_data_o  = tx_data_q;
    if (state_q == ST_BUSY) begin
      uart_tx_start_o = client_tx_start_i[client_q];
      uart_tx_data_o  = client_tx_data_i[{client_q, 3'b000} +: 8];
    end
  end

  assign soft_reset_o = soft_reset_q;
  assign grant_o      = grant_q;
  assign mode_o       = mode_q;
  assign status_o     = status_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_c2_arbiter_mc.sv
// Self-checking bench: four arbiter builds (default, NAK disabled, watchdog
// of 16 cycles, four clients with duplicate table bytes) share the stimulus
// buses; only the targeted build sees a receive strobe, the rest stay idle.
module tb_c2_arbiter_mc;

  localparam logic [3:0][7:0] TBL2 = {8'hCE, 8'hDE, 8'h1D, 8'h1C};
  localparam logic [7:0][7:0] TBL4 = {8'h87, 8'h76, 8'h87, 8'h21, 8'h43, 8'h32, 8'h21, 8'h10};

  localparam int P_ECHO = 0, P_EWAIT = 1, P_BUSY = 2, P_CLEAN = 3,
                 P_RECOV = 4, P_IDLE = 5, P_NAK = 6, P_NWAIT = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rxd;
  logic [3:0]  rxv;
  logic        txdone;
  logic [3:0]  cd;
  logic [3:0]  cts;
  logic [31:0] ctd;

  logic        ts  [4];
  logic [7:0]  tdo [4];
  logic        sr  [4];
  logic        md  [4];
  logic [1:0]  st  [4];
  logic        bz  [4];
  logic [1:0]  g0, g1, g2;
  logic [3:0]  g3;

  logic [1:0]  cur;
  logic [3:0]  gsel;
  logic [17:0] obs;

  int          errors = 0;
  int          checks = 0;
  logic [1:0]  exp_st [4];

  always #5 clk = ~clk;

  c2_arbiter_mc #(.NUM_CLIENTS(2), .CMD_TABLE(TBL2), .NAK_ENABLE(1'b1), .NAK_BYTE(8'hEE),
                  .TIMEOUT_CYCLES(0), .RESET_CYCLES(2)) u_d0 (
    .clk_i(clk), .rst_ni(rst_n), .uart_rx_data_i(rxd), .uart_rx_ready_i(rxv[0]),
    .uart_tx_data_o(tdo[0]), .uart_tx_start_o(ts[0]), .uart_tx_done_i(txdone),
    .soft_reset_o(sr[0]), .grant_o(g0), .mode_o(md[0]), .client_done_i(cd[1:0]),
    .client_tx_data_i(ctd[15:0]), .client_tx_start_i(cts[1:0]), .status_o(st[0]), .busy_o(bz[0]));

  c2_arbiter_mc #(.NUM_CLIENTS(2), .CMD_TABLE(TBL2), .NAK_ENABLE(1'b0), .NAK_BYTE(8'hEE),
                  .TIMEOUT_CYCLES(0), .RESET_CYCLES(2)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .uart_rx_data_i(rxd), .uart_rx_ready_i(rxv[1]),
    .uart_tx_data_o(tdo[1]), .uart_tx_start_o(ts[1]), .uart_tx_done_i(txdone),
    .soft_reset_o(sr[1]), .grant_o(g1), .mode_o(md[1]), .client_done_i(cd[1:0]),
    .client_tx_data_i(ctd[15:0]), .client_tx_start_i(cts[1:0]), .status_o(st[1]), .busy_o(bz[1]));

  c2_arbiter_mc #(.NUM_CLIENTS(2), .CMD_TABLE(TBL2), .NAK_ENABLE(1'b1), .NAK_BYTE(8'hEE),
                  .TIMEOUT_CYCLES(16), .RESET_CYCLES(2)) u_d2 (
    .clk_i(clk), .rst_ni(rst_n), .uart_rx_data_i(rxd), .uart_rx_ready_i(rxv[2]),
    .uart_tx_data_o(tdo[2]), .uart_tx_start_o(ts[2]), .uart_tx_done_i(txdone),
    .soft_reset_o(sr[2]), .grant_o(g2), .mode_o(md[2]), .client_done_i(cd[1:0]),
    .client_tx_data_i(ctd[15:0]), .client_tx_start_i(cts[1:0]), .status_o(st[2]), .busy_o(bz[2]));

  c2_arbiter_mc #(.NUM_CLIENTS(4), .CMD_TABLE(TBL4), .NAK_ENABLE(1'b1), .NAK_BYTE(8'hEE),
                  .TIMEOUT_CYCLES(0), .RESET_CYCLES(2)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .uart_rx_data_i(rxd), .uart_rx_ready_i(rxv[3]),
    .uart_tx_data_o(tdo[3]), .uart_tx_start_o(ts[3]), .uart_tx_done_i(txdone),
    .soft_reset_o(sr[3]), .grant_o(g3), .mode_o(md[3]), .client_done_i(cd),
    .client_tx_data_i(ctd), .client_tx_start_i(cts), .status_o(st[3]), .busy_o(bz[3]));

  always_comb begin
    case (cur)
      2'd0:    gsel = {2'b00, g0};
      2'd1:    gsel = {2'b00, g1};
      2'd2:    gsel = {2'b00, g2};
      default: gsel = g3;
    endcase
  end

  // {start, data[7:0], grant[3:0], mode, soft_reset, busy, status[1:0]}
  assign obs = {ts[cur], tdo[cur], gsel, md[cur], sr[cur], bz[cur], st[cur]};

  function automatic int nc_of(input int s);
    return (s == 3) ? 4 : 2;
  endfunction

  function automatic int tmo_of(input int s);
    return (s == 2) ? 16 : 0;
  endfunction

  function automatic logic [7:0] tbl_at(input int s, input int i);
    return (s == 3) ? TBL4[i] : TBL2[i];
  endfunction

  // First table entry equal to the byte, or -1 for an unknown command.
  function automatic int ref_match(input int s, input logic [7:0] c);
    for (int i = 0; i < 2*nc_of(s); i++)
      if (tbl_at(s, i) == c) return i;
    return -1;
  endfunction

  // One command from strobe to IDLE. The reference timeline is built from
  // phase lengths: ECHO 1, ECHO_WAIT e, BUSY up to done or watchdog,
  // CLEANUP 2, RECOVERY 1. Returns how many cycles grant and soft reset were seen.
  task automatic run_session(input int sel, input logic [7:0] cmd, input int e, input int d,
                             input string name, output int gcnt, output int scnt);
    int idx, c, m, tmo, bend, ph, b;
    bit nak, to, reached;
    logic [1:0]  newst;
    logic [17:0] ex;
    logic [3:0]  cbit;
    idx  = ref_match(sel, cmd);
    nak  = (idx < 0);
    c    = nak ? 0 : idx / 2;
    m    = nak ? 0 : idx % 2;
    cbit = 4'(1) << c;
    tmo  = tmo_of(sel);
    to   = !nak && (tmo != 0) && (d < 0 || d > tmo - 1);
    bend = to ? tmo - 1 : d;
    newst = nak ? 2'd1 : (to ? 2'd2 : 2'd0);
    cur = 2'(sel);
    ctd = $urandom; cts = 4'd0; cd = 4'd0; txdone = 1'b0;
    rxd = cmd; rxv = 4'(1) << sel;
    @(posedge clk); #1;
    rxv = 4'd0;
    gcnt = 0; scnt = 0; reached = 1'b0;
    for (int t = 0; t < 200; t++) begin
      b = 0;
      if (nak) begin
        if (sel == 1)   ph = P_IDLE;
        else if (t == 0) ph = P_NAK;
        else if (t <= e) ph = P_NWAIT;
        else             ph = P_IDLE;
      end else if (t == 0) ph = P_ECHO;
      else if (t <= e)     ph = P_EWAIT;
      else begin
        b = t - e - 1;
        if (b <= bend)              ph = P_BUSY;
        else if (b - bend - 1 < 2)  ph = P_CLEAN;
        else if (b - bend - 1 == 2) ph = P_RECOV;
        else                        ph = P_IDLE;
      end
      ex = '0;
      ex[17]   = (ph == P_ECHO || ph == P_NAK) ? 1'b1 : (ph == P_BUSY ? cts[c] : 1'b0);
      ex[16:9] = (ph == P_ECHO) ? cmd : (ph == P_NAK) ? 8'hEE : (ph == P_BUSY) ? ctd[8*c +: 8] : 8'h00;
      ex[8:5]  = (ph == P_BUSY) ? cbit : 4'd0;
      ex[4]    = !nak && (ph <= P_RECOV) && (m == 1);
      ex[3]    = (ph == P_CLEAN);
      ex[2]    = (ph != P_IDLE);
      ex[1:0]  = (!nak && ph <= P_BUSY) ? exp_st[sel] : newst;
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL %s t=%0d dut=%0d cmd=%h: got %h want %h", name, t, sel, cmd, obs, ex);
      end
      if (obs[8:5] != 4'd0) gcnt++;
      if (obs[3]) scnt++;
      if (ph == P_IDLE) begin
        reached = 1'b1;
        break;
      end
      txdone = (ph != P_BUSY) && (t == e);
      cts    = 4'($urandom);
      if (ph == P_BUSY) begin
        cd  = (4'($urandom) & ~cbit) | ((b == d) ? cbit : 4'd0);
        rxd = 8'hDE;
        rxv = ($urandom_range(0, 1) == 1) ? (4'(1) << sel) : 4'd0;
      end else begin
        cd  = 4'd0;
        rxv = 4'd0;
      end
      @(posedge clk); #1;
    end
    txdone = 1'b0; cd = 4'd0; rxv = 4'd0; cts = 4'd0;
    if (!reached) begin
      errors++;
      $display("FAIL %s no return to idle: got busy=%b want 0", name, obs[2]);
    end
    exp_st[sel] = newst;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rxd = 8'h00; rxv = 4'd0; txdone = 1'b0; cd = 4'd0; cts = 4'd0; ctd = '0;
    for (int s = 0; s < 4; s++) exp_st[s] = 2'd0;
    #12;
    for (int s = 0; s < 4; s++) begin
      cur = 2'(s);
      #1;
      checks++;
      if (obs !== 18'd0) begin
        errors++;
        $display("FAIL reset_outputs dut=%0d: got %h want 0", s, obs);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_client0();
    int g, s;
    run_session(0, 8'h1C, 3, 4, "basic_1c", g, s);
    checks++;
    if (g !== 5) begin errors++; $display("FAIL basic_grant_cycles: got %0d want 5", g); end
    checks++;
    if (s !== 2) begin errors++; $display("FAIL basic_soft_reset_cycles: got %0d want 2", s); end
  endtask

  task automatic test_client1_mode1();
    int g, s;
    run_session(0, 8'hCE, 0, 2, "client1_ce", g, s);
    checks++;
    if (g !== 3) begin errors++; $display("FAIL client1_grant_cycles: got %0d want 3", g); end
  endtask

  task automatic test_nak();
    int g, s;
    run_session(0, 8'hFF, 2, 0, "nak_on", g, s);
    checks++;
    if (g !== 0 || s !== 0) begin
      errors++; $display("FAIL nak_on_quiet: got grant=%0d soft=%0d want 0 0", g, s);
    end
    run_session(1, 8'hFF, 1, 0, "nak_off", g, s);
    checks++;
    if (g !== 0 || s !== 0) begin
      errors++; $display("FAIL nak_off_quiet: got grant=%0d soft=%0d want 0 0", g, s);
    end
  endtask

  task automatic test_timeout();
    int g, s;
    run_session(2, 8'h1D, 1, -1, "timeout", g, s);
    checks++;
    if (g !== 16) begin errors++; $display("FAIL timeout_grant_cycles: got %0d want 16", g); end
    checks++;
    if (st[2] !== 2'd2) begin errors++; $display("FAIL timeout_status: got %0d want 2", st[2]); end
    run_session(2, 8'h1D, 2, 15, "done_at_limit", g, s);
    checks++;
    if (g !== 16) begin errors++; $display("FAIL done_at_limit_grant: got %0d want 16", g); end
    checks++;
    if (st[2] !== 2'd0) begin errors++; $display("FAIL done_at_limit_status: got %0d want 0", st[2]); end
  endtask

  task automatic test_duplicates();
    int g, s;
    run_session(3, 8'h21, 1, 3, "dup_21", g, s);
    run_session(3, 8'h87, 0, 1, "dup_87", g, s);
    run_session(3, 8'h76, 2, 0, "client3", g, s);
    checks++;
    if (g !== 1 || s !== 2) begin
      errors++; $display("FAIL client3_counts: got grant=%0d soft=%0d want 1 2", g, s);
    end
  endtask

  task automatic test_reset_mid_busy();
    cur = 2'd0;
    rxd = 8'hDE; rxv = 4'b0001;
    @(posedge clk); #1;
    rxv = 4'd0; txdone = 1'b1;
    @(posedge clk); #1;
    txdone = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs[8:5] !== 4'b0010) begin
      errors++; $display("FAIL midbusy_grant: got %b want 0010", obs[8:5]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 18'd0) begin errors++; $display("FAIL midbusy_reset_outputs: got %h want 0", obs); end
    for (int s = 0; s < 4; s++) exp_st[s] = 2'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs[3] !== 1'b0 || obs[2] !== 1'b0) begin
        errors++; $display("FAIL midbusy_after: got soft=%b busy=%b want 0 0", obs[3], obs[2]);
      end
    end
  endtask

  task automatic test_random();
    int sel, idx, e, d, g, s;
    logic [7:0] cmd;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) cmd = tbl_at(sel, $urandom_range(0, 2*nc_of(sel) - 1));
      else                           cmd = 8'($urandom);
      idx = ref_match(sel, cmd);
      e   = (idx < 0) ? $urandom_range(1, 4) : $urandom_range(0, 4);
      d   = (sel == 2) ? $urandom_range(0, 20) : $urandom_range(0, 8);
      run_session(sel, cmd, e, d, "random", g, s);
    end
  endtask

  initial begin
    cur = 2'd0;
    test_reset();
    test_basic_client0();
    test_client1_mode1();
    test_nak();
    test_timeout();
    test_duplicates();
    test_reset_mid_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
